// File: rtl/clip_pkg.sv
// Shared types and helpers for the clip/round pipeline: lane rounding, output ceiling, clip flag pair.
package clip_pkg;

    localparam int unsigned RS_W = 32;

    // Per-lane clip indication; summed across lanes into the frame statistics.
    typedef struct packed {
        logic hi;
        logic lo;
    } clip_stat_t;

    // Round half toward +inf then arithmetic shift; shift 0 passes the value through.
    function automatic logic signed [RS_W-1:0] lane_round_shift(
        input logic signed [RS_W-1:0] x,
        input int unsigned            shift
    );
        logic signed [RS_W-1:0] r;
        r = x;
        if (shift != 0) begin
            r = x + (RS_W'(1) << (shift - 1));
        end
        return r >>> shift;
    endfunction

    function automatic int unsigned out_max(input int unsigned w);
        return (32'd1 << w) - 32'd1;
    endfunction

endpackage

// File: rtl/clip_round_stage_if.sv
// Beat, output and frame statistics bundle for clip_round_stage; slave is the block, master the upstream/downstream side.
interface clip_round_stage_if #(
    parameter int CHANNELS  = 3,
    parameter int IN_WIDTH  = 12,
    parameter int OUT_WIDTH = 8,
    parameter int CNT_WIDTH = 24
);
    logic                          valid_in;
    logic                          ready_out;
    logic [CHANNELS*IN_WIDTH-1:0]  data_in;
    logic                          last_in;
    logic                          valid_out;
    logic                          ready_in;
    logic [CHANNELS*OUT_WIDTH-1:0] data_out;
    logic                          last_out;
    logic [CHANNELS-1:0]           clip_hi_out;
    logic [CHANNELS-1:0]           clip_lo_out;
    logic                          stat_valid_out;
    logic [CNT_WIDTH-1:0]          stat_hi_count_out;
    logic [CNT_WIDTH-1:0]          stat_lo_count_out;

    modport slave (
        input  valid_in, data_in, last_in, ready_in,
        output ready_out, valid_out, data_out, last_out, clip_hi_out, clip_lo_out,
               stat_valid_out, stat_hi_count_out, stat_lo_count_out
    );

    modport master (
        output valid_in, data_in, last_in, ready_in,
        input  ready_out, valid_out, data_out, last_out, clip_hi_out, clip_lo_out,
               stat_valid_out, stat_hi_count_out, stat_lo_count_out
    );
endinterface

// File: rtl/clip_lane.sv
// One lane: round/shift of a raw input (stage 1 side) and saturation of a registered shifted value (stage 2 side).
// Purely combinational; no latency, no backpressure of its own.
module clip_lane
    import clip_pkg::*;
#(
    parameter int IN_WIDTH  = 12,
    parameter int OUT_WIDTH = 8,
    parameter int SHIFT     = 2
) (
    input  logic signed [IN_WIDTH-1:0] din_i,
    output logic signed [IN_WIDTH:0]   s_o,
    input  logic signed [IN_WIDTH:0]   s_i,
    output logic [OUT_WIDTH-1:0]       val_o,
    output clip_stat_t                 flag_o
);
    localparam int          S_W     = IN_WIDTH + 1;
    localparam int unsigned OUT_MAX = out_max(OUT_WIDTH);

    logic signed [RS_W-1:0] rs;
    logic                   unused_rs_hi;

    assign rs           = lane_round_shift({{(RS_W-IN_WIDTH){din_i[IN_WIDTH-1]}}, din_i}, SHIFT);
    assign s_o          = rs[S_W-1:0];
    assign unused_rs_hi = ^rs[RS_W-1:S_W];

    // Any set bit between the sign and the output field means the value exceeds OUT_MAX.
    always_comb begin
        val_o  = s_i[OUT_WIDTH-1:0];
        flag_o = '0;
        if (s_i[S_W-1]) begin
            val_o     = '0;
            flag_o.lo = 1'b1;
        end else if (|s_i[S_W-2:OUT_WIDTH]) begin
            val_o     = OUT_MAX[OUT_WIDTH-1:0];
            flag_o.hi = 1'b1;
        end
    end

endmodule

// File: rtl/clip_round_stage.sv
// Rounds, shifts and saturates CHANNELS lanes per beat and keeps per-frame clip counts; latency 2 cycles, 1 beat/cycle.
// Backpressure: elastic 2-stage valid/ready, ready_out is combinational from ready_in; outputs hold while stalled.
module clip_round_stage
    import clip_pkg::*;
#(
    parameter int CHANNELS  = 3,
    parameter int IN_WIDTH  = 12,
    parameter int OUT_WIDTH = 8,
    parameter int SHIFT     = 2,
    parameter int CNT_WIDTH = 24
) (
    input  logic                 clk_in,
    input  logic                 rst_n_in,
    clip_round_stage_if.slave    bus
);
    localparam int S_W   = IN_WIDTH + 1;
    localparam int PC_W  = $clog2(CHANNELS + 1);
    localparam int SUM_W = CNT_WIDTH + PC_W;

    logic [CHANNELS-1:0][S_W-1:0]       s_d, s_q;
    logic [CHANNELS-1:0][OUT_WIDTH-1:0] val_d;
    clip_stat_t [CHANNELS-1:0]          flag_d;
    logic [CHANNELS-1:0]                hi_d, lo_d;

    logic                          v1_q, last1_q;
    logic                          vout_q, last_q;
    logic [CHANNELS*OUT_WIDTH-1:0] dout_q;
    logic [CHANNELS-1:0]           hi_q, lo_q;

    logic                 adv1, adv2, out_hs;
    logic [PC_W-1:0]      hi_pc, lo_pc;
    logic [SUM_W-1:0]     hi_sum, lo_sum;
    logic [CNT_WIDTH-1:0] hi_sat, lo_sat;
    logic [CNT_WIDTH-1:0] hi_cnt_d, hi_cnt_q, lo_cnt_d, lo_cnt_q;
    logic [CNT_WIDTH-1:0] stat_hi_q, stat_lo_q;
    logic                 stat_vld_q;

    for (genvar k = 0; k < CHANNELS; k++) begin : g_lane
        clip_lane #(
            .IN_WIDTH  (IN_WIDTH),
            .OUT_WIDTH (OUT_WIDTH),
            .SHIFT     (SHIFT)
        ) u_lane (
            .din_i  (bus.data_in[k*IN_WIDTH +: IN_WIDTH]),
            .s_o    (s_d[k]),
            .s_i    (s_q[k]),
            .val_o  (val_d[k]),
            .flag_o (flag_d[k])
        );
        assign hi_d[k] = flag_d[k].hi;
        assign lo_d[k] = flag_d[k].lo;
    end

    assign adv2          = !vout_q || bus.ready_in;
    assign adv1          = !v1_q || adv2;
    assign out_hs        = vout_q && bus.ready_in;
    assign bus.ready_out = adv1;

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            v1_q    <= 1'b0;
            last1_q <= 1'b0;
            s_q     <= '0;
        end else if (adv1) begin
            v1_q <= bus.valid_in;
            if (bus.valid_in) begin
                s_q     <= s_d;
                last1_q <= bus.last_in;
            end
        end
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            vout_q <= 1'b0;
            last_q <= 1'b0;
            dout_q <= '0;
            hi_q   <= '0;
            lo_q   <= '0;
        end else if (adv2) begin
            vout_q <= v1_q;
            if (v1_q) begin
                dout_q <= val_d;
                hi_q   <= hi_d;
                lo_q   <= lo_d;
                last_q <= last1_q;
            end
        end
    end

    // Sums are one popcount wider than the counter so overflow is visible before saturation.
    always_comb begin
        hi_pc = '0;
        lo_pc = '0;
        for (int k = 0; k < CHANNELS; k++) begin
            hi_pc = hi_pc + PC_W'(hi_q[k]);
            lo_pc = lo_pc + PC_W'(lo_q[k]);
        end
        hi_sum = SUM_W'(hi_cnt_q) + SUM_W'(hi_pc);
        lo_sum = SUM_W'(lo_cnt_q) + SUM_W'(lo_pc);
        hi_sat = (|hi_sum[SUM_W-1:CNT_WIDTH]) ? '1 : hi_sum[CNT_WIDTH-1:0];
        lo_sat = (|lo_sum[SUM_W-1:CNT_WIDTH]) ? '1 : lo_sum[CNT_WIDTH-1:0];

        hi_cnt_d = hi_cnt_q;
        lo_cnt_d = lo_cnt_q;
        if (out_hs) begin
            hi_cnt_d = last_q ? '0 : hi_sat;
            lo_cnt_d = last_q ? '0 : lo_sat;
        end
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            hi_cnt_q   <= '0;
            lo_cnt_q   <= '0;
            stat_hi_q  <= '0;
            stat_lo_q  <= '0;
            stat_vld_q <= 1'b0;
        end else begin
            hi_cnt_q   <= hi_cnt_d;
            lo_cnt_q   <= lo_cnt_d;
            stat_vld_q <= out_hs && last_q;
            if (out_hs && last_q) begin
                stat_hi_q <= hi_sat;
                stat_lo_q <= lo_sat;
            end
        end
    end

    assign bus.valid_out         = vout_q;
    assign bus.data_out          = dout_q;
    assign bus.last_out          = last_q;
    assign bus.clip_hi_out       = hi_q;
    assign bus.clip_lo_out       = lo_q;
    assign bus.stat_valid_out    = stat_vld_q;
    assign bus.stat_hi_count_out = stat_hi_q;
    assign bus.stat_lo_count_out = stat_lo_q;

endmodule

// File: tb/tb_clip_round_stage.sv
// Directed bench for clip_round_stage: rounding, clipping, backpressure, frame stats, counter saturation, async reset.
module tb_clip_round_stage;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   n_checks = 0;
    int   n_fail   = 0;

    always #5 clk = ~clk;

    clip_round_stage_if #(.CHANNELS(3), .IN_WIDTH(12), .OUT_WIDTH(8), .CNT_WIDTH(24)) bus ();
    clip_round_stage_if #(.CHANNELS(3), .IN_WIDTH(12), .OUT_WIDTH(8), .CNT_WIDTH(2))  bus2 ();

    clip_round_stage #(.CHANNELS(3), .IN_WIDTH(12), .OUT_WIDTH(8), .SHIFT(2), .CNT_WIDTH(24)) dut (
        .clk_in   (clk),
        .rst_n_in (rst_n),
        .bus      (bus)
    );

    clip_round_stage #(.CHANNELS(3), .IN_WIDTH(12), .OUT_WIDTH(8), .SHIFT(2), .CNT_WIDTH(2)) dut2 (
        .clk_in   (clk),
        .rst_n_in (rst_n),
        .bus      (bus2)
    );

    function automatic logic [35:0] pk(input int a, input int b, input int c);
        logic [11:0] la, lb, lc;
        la = a[11:0];
        lb = b[11:0];
        lc = c[11:0];
        return {lc, lb, la};
    endfunction

    function automatic logic [23:0] po(input int a, input int b, input int c);
        logic [7:0] la, lb, lc;
        la = a[7:0];
        lb = b[7:0];
        lc = c[7:0];
        return {lc, lb, la};
    endfunction

    task automatic idle_inputs();
        bus.valid_in  = 1'b0;
        bus.data_in   = '0;
        bus.last_in   = 1'b0;
        bus.ready_in  = 1'b1;
        bus2.valid_in = 1'b0;
        bus2.data_in  = '0;
        bus2.last_in  = 1'b0;
        bus2.ready_in = 1'b1;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        n_checks++;
        if (bus.valid_out !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", bus.valid_out); end
        n_checks++;
        if (bus.data_out !== 24'd0 || bus.last_out !== 1'b0) begin
            n_fail++; $display("FAIL reset_data: got %h/%b want 0/0", bus.data_out, bus.last_out);
        end
        n_checks++;
        if (bus.clip_hi_out !== 3'b000 || bus.clip_lo_out !== 3'b000) begin
            n_fail++; $display("FAIL reset_flags: got %b/%b want 000/000", bus.clip_hi_out, bus.clip_lo_out);
        end
        n_checks++;
        if (bus.stat_valid_out !== 1'b0 || bus.stat_hi_count_out !== 24'd0 || bus.stat_lo_count_out !== 24'd0) begin
            n_fail++; $display("FAIL reset_stats: got %b %0d %0d want 0 0 0", bus.stat_valid_out,
                               bus.stat_hi_count_out, bus.stat_lo_count_out);
        end
        n_checks++;
        if (bus.ready_out !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b want 1", bus.ready_out); end
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_rounding();
        do_reset();
        bus.valid_in = 1'b1;
        bus.data_in  = pk(6, 5, 1021);
        @(posedge clk);
        #1 bus.valid_in = 1'b0;
        n_checks++;
        if (bus.valid_out !== 1'b0) begin n_fail++; $display("FAIL round_lat1: valid_out %b want 0", bus.valid_out); end
        @(posedge clk);
        #1;
        n_checks++;
        if (bus.valid_out !== 1'b1 || bus.data_out !== po(2, 1, 255)) begin
            n_fail++; $display("FAIL round_data: got v=%b %h want v=1 %h", bus.valid_out, bus.data_out, po(2, 1, 255));
        end
        n_checks++;
        if (bus.clip_hi_out !== 3'b000 || bus.clip_lo_out !== 3'b000) begin
            n_fail++; $display("FAIL round_flags: got %b/%b want 000/000", bus.clip_hi_out, bus.clip_lo_out);
        end
        @(posedge clk);
        #1;
        n_checks++;
        if (bus.valid_out !== 1'b0) begin n_fail++; $display("FAIL round_pulse: valid_out %b want 0", bus.valid_out); end
    endtask

    task automatic test_clip();
        do_reset();
        bus.valid_in = 1'b1;
        bus.data_in  = pk(1023, -3, 2047);
        @(posedge clk);
        #1 bus.data_in = pk(-1, 0, 3);
        @(posedge clk);
        #1 bus.valid_in = 1'b0;
        n_checks++;
        if (bus.valid_out !== 1'b1 || bus.data_out !== po(255, 0, 255)) begin
            n_fail++; $display("FAIL clip_data: got v=%b %h want v=1 %h", bus.valid_out, bus.data_out, po(255, 0, 255));
        end
        n_checks++;
        if (bus.clip_hi_out !== 3'b101 || bus.clip_lo_out !== 3'b010) begin
            n_fail++; $display("FAIL clip_flags: got %b/%b want 101/010", bus.clip_hi_out, bus.clip_lo_out);
        end
        @(posedge clk);
        #1;
        n_checks++;
        if (bus.valid_out !== 1'b1 || bus.data_out !== po(0, 0, 1)) begin
            n_fail++; $display("FAIL clip_neg1_data: got v=%b %h want v=1 %h", bus.valid_out, bus.data_out, po(0, 0, 1));
        end
        n_checks++;
        if (bus.clip_hi_out !== 3'b000 || bus.clip_lo_out !== 3'b000) begin
            n_fail++; $display("FAIL clip_neg1_flags: got %b/%b want 000/000", bus.clip_hi_out, bus.clip_lo_out);
        end
    endtask

    task automatic test_backpressure();
        int sent;
        int rx;
        logic [23:0] exp;
        do_reset();
        sent = 0;
        rx   = 0;
        for (int cyc = 0; cyc < 16; cyc++) begin
            bus.ready_in = (cyc < 2 || cyc >= 6);
            if (sent < 5) begin
                bus.valid_in = 1'b1;
                bus.data_in  = pk(40*sent, 40*sent + 4, 40*sent + 8);
            end else begin
                bus.valid_in = 1'b0;
            end
            #1;
            if (cyc >= 2 && cyc < 6) begin
                n_checks++;
                if (bus.ready_out !== 1'b0) begin
                    n_fail++; $display("FAIL bp_ready cyc%0d: got %b want 0", cyc, bus.ready_out);
                end
                n_checks++;
                if (bus.valid_out !== 1'b1 || bus.data_out !== po(0, 1, 2)) begin
                    n_fail++; $display("FAIL bp_hold cyc%0d: got v=%b %h want v=1 %h", cyc, bus.valid_out,
                                       bus.data_out, po(0, 1, 2));
                end
            end
            if (bus.valid_out && bus.ready_in) begin
                exp = po(10*rx, 10*rx + 1, 10*rx + 2);
                n_checks++;
                if (bus.data_out !== exp) begin
                    n_fail++; $display("FAIL bp_order beat%0d: got %h want %h", rx, bus.data_out, exp);
                end
                rx++;
            end
            if (bus.valid_in && bus.ready_out) sent++;
            @(posedge clk);
            #1;
        end
        idle_inputs();
        n_checks++;
        if (rx != 5) begin n_fail++; $display("FAIL bp_count: got %0d beats want 5", rx); end
    endtask

    task automatic test_frame_stats();
        logic [35:0] beats [4];
        int          pulses;
        logic [23:0] cap_hi, cap_lo;
        do_reset();
        beats[0] = pk(1023, 0, 0);
        beats[1] = pk(0, -3, 0);
        beats[2] = pk(1023, 2047, 4);
        beats[3] = pk(4, 8, 12);
        pulses = 0;
        cap_hi = '0;
        cap_lo = '0;
        for (int cyc = 0; cyc < 10; cyc++) begin
            bus.valid_in = (cyc < 4);
            bus.data_in  = (cyc < 4) ? beats[cyc] : '0;
            bus.last_in  = (cyc == 3);
            #1;
            if (bus.stat_valid_out) begin
                pulses++;
                cap_hi = bus.stat_hi_count_out;
                cap_lo = bus.stat_lo_count_out;
            end
            @(posedge clk);
            #1;
        end
        n_checks++;
        if (pulses != 1) begin n_fail++; $display("FAIL frame_pulses: got %0d want 1", pulses); end
        n_checks++;
        if (cap_hi !== 24'd3 || cap_lo !== 24'd1) begin
            n_fail++; $display("FAIL frame_counts: got hi=%0d lo=%0d want hi=3 lo=1", cap_hi, cap_lo);
        end
        pulses = 0;
        for (int cyc = 0; cyc < 8; cyc++) begin
            bus.valid_in = (cyc == 0);
            bus.data_in  = pk(-3, 0, 1023);
            bus.last_in  = (cyc == 0);
            #1;
            if (bus.stat_valid_out) begin
                pulses++;
                cap_hi = bus.stat_hi_count_out;
                cap_lo = bus.stat_lo_count_out;
            end
            @(posedge clk);
            #1;
        end
        idle_inputs();
        n_checks++;
        if (pulses != 1 || cap_hi !== 24'd1 || cap_lo !== 24'd1) begin
            n_fail++; $display("FAIL frame2_counts: got pulses=%0d hi=%0d lo=%0d want 1 1 1", pulses, cap_hi, cap_lo);
        end
    endtask

    task automatic test_saturation();
        int         pulses;
        logic [1:0] cap_hi, cap_lo;
        do_reset();
        pulses = 0;
        cap_hi = '0;
        cap_lo = '1;
        for (int cyc = 0; cyc < 9; cyc++) begin
            bus2.valid_in = (cyc < 3);
            bus2.data_in  = pk(1023, 1023, 1023);
            bus2.last_in  = (cyc == 2);
            #1;
            if (bus2.stat_valid_out) begin
                pulses++;
                cap_hi = bus2.stat_hi_count_out;
                cap_lo = bus2.stat_lo_count_out;
            end
            @(posedge clk);
            #1;
        end
        idle_inputs();
        n_checks++;
        if (pulses != 1 || cap_hi !== 2'd3 || cap_lo !== 2'd0) begin
            n_fail++; $display("FAIL sat_counts: got pulses=%0d hi=%0d lo=%0d want 1 3 0", pulses, cap_hi, cap_lo);
        end
    endtask

    task automatic test_async_reset();
        int          pulses;
        logic [23:0] cap_hi, cap_lo;
        do_reset();
        bus.valid_in = 1'b1;
        bus.data_in  = pk(1023, 1023, 1023);
        @(posedge clk);
        #1 bus.valid_in = 1'b0;
        repeat (2) @(posedge clk);
        #1 bus.ready_in = 1'b0;
        bus.valid_in = 1'b1;
        bus.data_in  = pk(1023, 0, 0);
        @(posedge clk);
        #1 bus.data_in = pk(0, -3, 0);
        @(posedge clk);
        #1 bus.valid_in = 1'b0;
        n_checks++;
        if (bus.valid_out !== 1'b1 || bus.ready_out !== 1'b0) begin
            n_fail++; $display("FAIL arst_full: got v=%b rdy=%b want v=1 rdy=0", bus.valid_out, bus.ready_out);
        end
        #2 rst_n = 1'b0;
        #1;
        n_checks++;
        if (bus.valid_out !== 1'b0 || bus.stat_valid_out !== 1'b0) begin
            n_fail++; $display("FAIL arst_clear: got v=%b sv=%b want 0 0", bus.valid_out, bus.stat_valid_out);
        end
        @(posedge clk);
        #1 rst_n = 1'b1;
        bus.ready_in = 1'b1;
        pulses = 0;
        cap_hi = '0;
        cap_lo = '0;
        for (int cyc = 0; cyc < 4; cyc++) begin
            #1;
            if (bus.stat_valid_out) pulses++;
            @(posedge clk);
            #1;
        end
        n_checks++;
        if (pulses != 0) begin n_fail++; $display("FAIL arst_no_pulse: got %0d pulses want 0", pulses); end
        for (int cyc = 0; cyc < 8; cyc++) begin
            bus.valid_in = (cyc == 0);
            bus.data_in  = pk(1023, -3, 0);
            bus.last_in  = (cyc == 0);
            #1;
            if (bus.stat_valid_out) begin
                pulses++;
                cap_hi = bus.stat_hi_count_out;
                cap_lo = bus.stat_lo_count_out;
            end
            @(posedge clk);
            #1;
        end
        idle_inputs();
        n_checks++;
        if (pulses != 1 || cap_hi !== 24'd1 || cap_lo !== 24'd1) begin
            n_fail++; $display("FAIL arst_frame: got pulses=%0d hi=%0d lo=%0d want 1 1 1", pulses, cap_hi, cap_lo);
        end
    endtask

    initial begin
        idle_inputs();
        test_reset();
        test_rounding();
        test_clip();
        test_backpressure();
        test_frame_stats();
        test_saturation();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
